multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

- Sequencing controller for the multi-cycle variant of the RISC-V core.
- Walks each instruction through fetch, decode, execute, memory and writeback.
- Drives the immediate generator's 5-bit type select, ALU/PC/writeback muxes, and the instruction- and data-memory request handshakes.
- Sits between the instruction register and the shared datapath (immediate generator, ALU, register file, PC).

## Interface
Parameters:
- (none)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0] from instruction register
- branch_taken  in  1  ALU compare result for current branch
- imem_ready  in  1  instruction memory accepts/returns word this cycle
- dmem_ready  in  1  data memory completes access this cycle
- imem_req  out  1  fetch request
- ir_write  out  1  load instruction register
- dmem_req  out  1  data access request
- dmem_we  out  1  data access is a store
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 ALU, 01 memory, 10 PC+4
- alu_src_a  out  2  00 rs1, 01 PC, 10 zero
- alu_src_b  out  1  0 rs2, 1 immediate
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- imm_sel  out  5  immediate type select = latched opcode[6:2]
- pc_write  out  1  PC update enable
- pc_src  out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
- halted  out  1  core stopped on illegal opcode
- state_dbg  out  3  current state encoding

## Operation
- Moore FSM; states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1; hold until imem_ready.
  - On imem_ready: ir_write=1, go to DECODE.
- DECODE:
  - Latch opcode[6:2] into op_q.
  - imm_sel follows op_q from the next cycle onward.
  - Legal: 00100 OP-IMM, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR, 00101 AUIPC, 01101 LUI, 01100 OP, 00011 FENCE.
  - FENCE: pc_write=1, pc_src=00, go to FETCH (NOP).
  - Illegal opcode: see Configuration. All other legal opcodes go to EXEC.
- EXEC:
  - OP: a=rs1, b=rs2, alu_op=10.
  - OP-IMM: b=imm, alu_op=10.
  - LOAD/STORE: a=rs1, b=imm, add. Go to MEM.
  - LUI: a=zero, b=imm.
  - AUIPC: a=PC, b=imm.
  - BRANCH: alu_op=01, pc_write=1, pc_src = branch_taken ? 01 : 00. Go to FETCH.
  - JAL: pc_write, pc_src=01 deferred to WB.
  - JALR: pc_src=10 deferred to WB; ALU computes rs1+imm.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR go to WB.
- MEM:
  - dmem_req=1, dmem_we=(STORE). Hold until dmem_ready.
  - LOAD goes to WB.
  - STORE: pc_write=1, pc_src=00, go to FETCH.
- WB:
  - reg_write=1, pc_write=1, go to FETCH.
  - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_src: 01 JAL, 10 JALR (uses ALU result held in ALU output register), else 00.
- Exactly one pc_write pulse per retired instruction.
- Zero-wait cycles per instruction: BRANCH 3, OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5, FENCE 2.

## Timing
- rst asserted (any state, including mid-MEM with dmem_req high):
  - state=FETCH, op_q=0.
  - All outputs forced 0, state_dbg=0.
  - The outstanding memory request is dropped.
- First cycle after rst release: FETCH with imem_req=1.
- Ready inputs are sampled at the rising edge. Ready high in the same cycle as the request completes the access that cycle.
- Ready inputs are ignored outside FETCH/MEM.
- imem_req/dmem_req stay high and stable until accepted.
- imm_sel, alu_src_*, and alu_op are stable for the whole EXEC and WB states.
- branch_taken is sampled only in EXEC of a BRANCH.

## Configuration
- ILLEGAL_OP_HALT_EN defined:
  - Illegal opcode in DECODE goes to HALT.
  - HALT: halted=1, all enables 0. Exit only by rst.
- Not defined:
  - Illegal opcode is treated as NOP: pc_write=1, pc_src=00, go to FETCH.
  - halted tied to 0; HALT state unreachable.

## Structure
- Package riscv_ctrl_pkg holds:
  - state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5);
  - opcode[6:2] constants (shared with the immediate generator);
  - wb_sel, alu_src_a, alu_op, and pc_src encodings.
- One sub-module, opcode_classifier: combinational op_q → {legal, is_load, is_store, is_branch, is_jal, is_jalr, uses_imm, is_fence}.

## Test plan
- ADDI (opcode 0010011), imem_ready tied 1:
  - FETCH→DECODE→EXEC→WB→FETCH in 4 cycles.
  - imm_sel=00100, alu_src_b=1, reg_write=1 in WB only, single pc_write with pc_src=00.
- LW (0000011), dmem_ready low 3 cycles:
  - dmem_req held 4 cycles with dmem_we=0.
  - WB has wb_sel=01; 8 cycles total.
- BEQ (1100011):
  - branch_taken=1 → pc_src=01 with pc_write in EXEC.
  - branch_taken=0 → pc_src=00; 3 cycles, reg_write never asserted.
- JALR (1100111):
  - imm_sel=11001; WB asserts reg_write, wb_sel=10, pc_src=10.
- Opcode 1111111:
  - With ILLEGAL_OP_HALT_EN: halted=1 from the cycle after DECODE, no further imem_req.
  - Without: pc_write/pc_src=00, back to FETCH.
- rst pulsed while in MEM with dmem_req=1:
  - dmem_req drops immediately, state_dbg=0.
  - After release, imem_req=1 in the first cycle.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: state, opcode[6:2] and datapath mux encodings for the multi-cycle controller
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [1:0] WB_ALU      = 2'b00;
  localparam logic [1:0] WB_MEM      = 2'b01;
  localparam logic [1:0] WB_PC4      = 2'b10;
  localparam logic [1:0] SRCA_RS1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ZERO   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PC_PLUS4    = 2'b00;
  localparam logic [1:0] PC_IMM      = 2'b01;
  localparam logic [1:0] PC_REG      = 2'b10;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational decode of opcode[6:2] into instruction-class flags
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output logic       legal_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_branch_o,
  output logic       is_jal_o,
  output logic       is_jalr_o,
  output logic       uses_imm_o,
  output logic       is_fence_o
);
  always_comb begin
    legal_o     = op_i inside {OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                               OPC_JALR, OPC_AUIPC, OPC_LUI, OPC_OP, OPC_FENCE};
    is_load_o   = op_i == OPC_LOAD;
    is_store_o  = op_i == OPC_STORE;
    is_branch_o = op_i == OPC_BRANCH;
    is_jal_o    = op_i == OPC_JAL;
    is_jalr_o   = op_i == OPC_JALR;
    uses_imm_o  = op_i inside {OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC,
                               OPC_JAL, OPC_JALR};
    is_fence_o  = op_i == OPC_FENCE;
  end
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer; define ILLEGAL_OP_HALT_EN to halt on illegal opcodes
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_write,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [4:0] imm_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       halted,
  output logic [2:0] state_dbg
);
`ifdef ILLEGAL_OP_HALT_EN
  localparam state_e ILL_NXT = ST_HALT;
  localparam logic   ILL_NOP = 1'b0;
`else
  localparam state_e ILL_NXT = ST_FETCH;
  localparam logic   ILL_NOP = 1'b1;
`endif
  state_e     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       legal, is_load, is_store, is_branch, is_jal, is_jalr, uses_imm, is_fence;
  logic       run, dec_ok, alu_act, dec_nop, br_exec, st_done, in_wb;
  // DECODE classifies the live opcode; later states use the latched copy
  assign op_d   = (state_q == ST_DECODE) ? opcode[6:2] : op_q;
  assign dec_ok = legal & (&opcode[1:0]);
  opcode_classifier u_cls (
    .op_i       (op_d),
    .legal_o    (legal),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .is_branch_o(is_branch),
    .is_jal_o   (is_jal),
    .is_jalr_o  (is_jalr),
    .uses_imm_o (uses_imm),
    .is_fence_o (is_fence)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = imem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_d = !dec_ok ? ILL_NXT : is_fence ? ST_FETCH : ST_EXEC;
      ST_EXEC:   state_d = (is_load | is_store) ? ST_MEM : is_branch ? ST_FETCH : ST_WB;
      ST_MEM:    state_d = !dmem_ready ? ST_MEM : is_load ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end
  // reset masks every output so an in-flight request drops immediately
  assign run     = ~rst;
  assign alu_act = run & (state_q inside {ST_EXEC, ST_MEM, ST_WB});
  assign dec_nop = run & (state_q == ST_DECODE) & (dec_ok ? is_fence : ILL_NOP);
  assign br_exec = run & (state_q == ST_EXEC) & is_branch;
  assign st_done = run & (state_q == ST_MEM) & dmem_ready & is_store;
  assign in_wb   = run & (state_q == ST_WB);
  always_comb begin
    imem_req  = run & (state_q == ST_FETCH);
    ir_write  = imem_req & imem_ready;
    dmem_req  = run & (state_q == ST_MEM);
    dmem_we   = dmem_req & is_store;
    reg_write = in_wb;
    wb_sel    = !in_wb ? WB_ALU : is_load ? WB_MEM : (is_jal | is_jalr) ? WB_PC4 : WB_ALU;
    alu_src_a = !alu_act ? SRCA_RS1 : (op_q == OPC_LUI) ? SRCA_ZERO :
                (op_q == OPC_AUIPC) ? SRCA_PC : SRCA_RS1;
    alu_src_b = alu_act & uses_imm;
    alu_op    = !alu_act ? ALUOP_ADD : (op_q inside {OPC_OP, OPC_OPIMM}) ? ALUOP_FUNCT :
                is_branch ? ALUOP_BR : ALUOP_ADD;
    imm_sel   = run ? op_q : 5'd0;
    pc_write  = dec_nop | br_exec | st_done | in_wb;
    pc_src    = (br_exec & branch_taken) ? PC_IMM : (in_wb & is_jal) ? PC_IMM :
                (in_wb & is_jalr) ? PC_REG : PC_PLUS4;
`ifdef ILLEGAL_OP_HALT_EN
    halted    = run & (state_q == ST_HALT);
`else
    halted    = 1'b0;
`endif
    state_dbg = run ? 3'(state_q) : 3'd0;
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: per-instruction cycle scripts built from the instruction rules, checked every cycle
module tb_multicycle_control_fsm;
  typedef struct packed {
    logic       imem_req, ir_write, dmem_req, dmem_we, reg_write;
    logic [1:0] wb_sel, alu_src_a;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic [4:0] imm_sel;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       halted;
    logic [2:0] state_dbg;
  } o_t;
  typedef struct packed {
    logic       rs, ir, dr, bt;
    logic [6:0] op;
    o_t         o;
  } cyc_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, ir_write, dmem_req, dmem_we, reg_write, alu_src_b, pc_write, halted;
  logic [1:0] wb_sel, alu_src_a, alu_op, pc_src;
  logic [4:0] imm_sel;
  logic [2:0] state_dbg;
  o_t         act;
  cyc_t       q[$];
  logic [4:0] prev = '0;
  logic [4:0] legal_ops [10] = '{5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011,
                                 5'b11001, 5'b00101, 5'b01101, 5'b01100, 5'b00011};
  int         checks = 0, failures = 0, ncyc = 0;
  always #5 clk = ~clk;
  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .pc_write(pc_write), .pc_src(pc_src), .halted(halted),
    .state_dbg(state_dbg)
  );
  assign act = {imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel, alu_src_a,
                alu_src_b, alu_op, imm_sel, pc_write, pc_src, halted, state_dbg};
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic cyc_t blank(input logic [6:0] op, input logic [2:0] st);
    cyc_t c = '0;
    c.ir = 1'($urandom);
    c.dr = 1'($urandom);
    c.bt = 1'($urandom);
    c.op = op;
    c.o.state_dbg = st;
    c.o.imm_sel = prev;
    return c;
  endfunction
  function automatic cyc_t rst_cyc();
    cyc_t c = '0;
    c.rs = 1'b1;
    c.ir = 1'($urandom);
    c.dr = 1'($urandom);
    c.bt = 1'($urandom);
    c.op = 7'($urandom);
    return c;
  endfunction
  // datapath selects held through EXEC, MEM and WB
  function automatic cyc_t alu(input cyc_t c, input logic [4:0] o);
    c.o.alu_src_a = (o == 5'b01101) ? 2'b10 : (o == 5'b00101) ? 2'b01 : 2'b00;
    c.o.alu_src_b = o inside {5'b00100, 5'b00000, 5'b01000, 5'b01101, 5'b00101,
                              5'b11011, 5'b11001};
    c.o.alu_op = (o inside {5'b01100, 5'b00100}) ? 2'b10 : (o == 5'b11000) ? 2'b01 : 2'b00;
    return c;
  endfunction
  task automatic gen(input logic [6:0] op7, input int iw, input int dw, input int bt,
                     input bit abort);
    logic [4:0] o;
    bit legal, ld, st, br, jal, jalr, fence;
    cyc_t c;
    o = op7[6:2];
    legal = (op7[1:0] == 2'b11) && (o inside {5'b00100, 5'b00000, 5'b01000, 5'b11000,
            5'b11011, 5'b11001, 5'b00101, 5'b01101, 5'b01100, 5'b00011});
    ld = legal && o == 5'b00000;
    st = legal && o == 5'b01000;
    br = legal && o == 5'b11000;
    jal = legal && o == 5'b11011;
    jalr = legal && o == 5'b11001;
    fence = legal && o == 5'b00011;
    for (int i = 0; i <= iw; i++) begin
      c = blank(op7, 3'd0);
      c.ir = (i == iw);
      c.o.imem_req = 1'b1;
      c.o.ir_write = c.ir;
      q.push_back(c);
    end
    c = blank(op7, 3'd1);
`ifdef ILLEGAL_OP_HALT_EN
    c.o.pc_write = fence;
`else
    c.o.pc_write = fence || !legal;
`endif
    q.push_back(c);
    prev = o;
    if (!legal) begin
`ifdef ILLEGAL_OP_HALT_EN
      for (int i = 0; i < 3; i++) begin
        c = blank(op7, 3'd5);
        c.o.halted = 1'b1;
        q.push_back(c);
      end
      q.push_back(rst_cyc());
      prev = '0;
`endif
      return;
    end
    if (fence) return;
    c = alu(blank(op7, 3'd2), o);
    if (bt >= 0) c.bt = 1'(bt);
    if (br) begin
      c.o.pc_write = 1'b1;
      c.o.pc_src = c.bt ? 2'b01 : 2'b00;
      q.push_back(c);
      return;
    end
    q.push_back(c);
    if (ld || st) begin
      for (int i = 0; i <= dw; i++) begin
        if (abort && i == 2) begin
          q.push_back(rst_cyc());
          prev = '0;
          return;
        end
        c = alu(blank(op7, 3'd3), o);
        c.dr = (i == dw);
        c.o.dmem_req = 1'b1;
        c.o.dmem_we = st;
        c.o.pc_write = st && c.dr;
        q.push_back(c);
      end
      if (st) return;
    end
    c = alu(blank(op7, 3'd4), o);
    c.o.reg_write = 1'b1;
    c.o.pc_write = 1'b1;
    c.o.wb_sel = ld ? 2'b01 : (jal || jalr) ? 2'b10 : 2'b00;
    c.o.pc_src = jal ? 2'b01 : jalr ? 2'b10 : 2'b00;
    q.push_back(c);
  endtask
  task automatic play();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst = c.rs;
      imem_ready = c.ir;
      dmem_ready = c.dr;
      branch_taken = c.bt;
      opcode = c.op;
      @(negedge clk);
      ncyc++;
      cmp($sformatf("cyc%0d op=%b rst=%b", ncyc, c.op, c.rs), 32'(act), 32'(c.o));
    end
  endtask
  initial begin
    logic [6:0] op7;
    bit ab;
    q.push_back(rst_cyc());
    q.push_back(rst_cyc());
    play();
    gen(7'b0010011, 0, 0, -1, 0);
    cmp("addi_len", q.size(), 4);
    cmp("addi_wb", 32'(q[3].o), 32'({5'b00001, 2'b00, 2'b00, 1'b1, 2'b10, 5'b00100, 1'b1, 2'b00, 1'b0, 3'd4}));
    play();
    gen(7'b0000011, 0, 3, -1, 0);
    cmp("lw_len", q.size(), 8);
    cmp("lw_wb_sel", 32'(q[7].o.wb_sel), 32'd1);
    play();
    gen(7'b1100011, 0, 0, 1, 0);
    cmp("beq_t_len", q.size(), 3);
    cmp("beq_t_pc_src", 32'(q[2].o.pc_src), 32'd1);
    play();
    gen(7'b1100011, 0, 0, 0, 0);
    cmp("beq_n_pc_src", 32'(q[2].o.pc_src), 32'd0);
    play();
    gen(7'b1100111, 1, 0, -1, 0);
    cmp("jalr_wb", 32'(q[4].o), 32'({5'b00001, 2'b10, 2'b00, 1'b1, 2'b00, 5'b11001, 1'b1, 2'b10, 1'b0, 3'd4}));
    play();
    gen(7'b0100011, 0, 0, -1, 0);
    cmp("sw_len", q.size(), 4);
    play();
    gen(7'b0001111, 0, 0, -1, 0);
    cmp("fence_len", q.size(), 2);
    play();
    foreach (legal_ops[i]) begin
      gen({legal_ops[i], 2'b11}, 0, 1, -1, 0);
      play();
    end
    gen(7'b1111111, 0, 0, -1, 0);
    play();
    gen(7'b0000011, 0, 5, -1, 1);
    play();
    gen(7'b0110011, 0, 0, -1, 0);
    play();
    for (int n = 0; n < 300; n++) begin
      op7 = ($urandom_range(0, 9) != 0) ? {legal_ops[$urandom_range(0, 9)], 2'b11} : 7'($urandom);
      ab = ($urandom_range(0, 24) == 0);
      gen(op7, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
          ab ? 5 : $urandom_range(0, 3), -1, ab);
      play();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
